// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio gain pipeline: defaults, unity gain,
// gain ramp state and the shift-then-saturate arithmetic.
package audio_pkg;

   localparam int unsigned WIDTH_DEF    = 24;
   localparam int unsigned CHANNELS_DEF = 2;
   localparam int unsigned GAIN_W_DEF   = 8;

   // Wide enough for any product of WIDTH + GAIN_W + 1 bits up to 64.
   localparam int unsigned ARITH_W = 64;

   typedef enum logic [1:0] {
      HOLD,
      UP,
      DOWN
   } ramp_state_e;

   typedef struct packed {
      logic                sat;
      logic [ARITH_W-1:0]  value;
   } sat_res_t;

   function automatic int unsigned gain_unity(input int unsigned gain_w);
      return 32'd1 << (gain_w - 1);
   endfunction

   function automatic sat_res_t sat_shift(input logic signed [ARITH_W-1:0] product,
                                          input int unsigned shift,
                                          input int unsigned width);
      logic signed [ARITH_W-1:0] shifted;
      logic signed [ARITH_W-1:0] max_v;
      logic signed [ARITH_W-1:0] min_v;
      sat_res_t                  res;
      shifted = product >>> shift;
      max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v   = -max_v - 64'sd1;
      res.sat = 1'b1;
      if (shifted > max_v) begin
         res.value = max_v;
      end else if (shifted < min_v) begin
         res.value = min_v;
      end else begin
         res.sat   = 1'b0;
         res.value = shifted;
      end
      return res;
   endfunction

endpackage

// File: rtl/audio_gain_ch.sv
// Single-channel gain stage: signed sample times unsigned Q1.x gain, arithmetic
// shift back to sample scale, then clamp. Purely combinational.
module audio_gain_ch
   import audio_pkg::*;
#(
   parameter int unsigned WIDTH_P  = WIDTH_DEF,
   parameter int unsigned GAIN_W_P = GAIN_W_DEF
) (
   input  logic [WIDTH_P-1:0]  sample_i,
   input  logic [GAIN_W_P-1:0] gain_i,
   output logic [WIDTH_P-1:0]  result_o,
   output logic                sat_o
);

   localparam int unsigned PROD_W = WIDTH_P + GAIN_W_P + 1;

   logic signed [PROD_W-1:0] product;
   sat_res_t                 res;
   logic                     unused_hi;

   // Zero-extend the gain by one bit so the multiply stays signed throughout.
   assign product = PROD_W'($signed(sample_i)) * PROD_W'($signed({1'b0, gain_i}));
   assign res     = sat_shift(ARITH_W'(product), GAIN_W_P - 1, WIDTH_P);

   assign result_o  = res.value[WIDTH_P-1:0];
   assign sat_o     = res.sat;
   assign unused_hi = ^res.value[ARITH_W-1:WIDTH_P];

endmodule

// File: rtl/audio_gain_pipe.sv
// N-channel two-stage valid/ready audio pipeline with ramped gain and saturation.
// Define AUDIO_GAIN_PEAK_EN to add the per-channel peak meter (peak_clr_i/peak_o).
module audio_gain_pipe
   import audio_pkg::*;
#(
   parameter int unsigned WIDTH_P     = WIDTH_DEF,
   parameter int unsigned CHANNELS_P  = CHANNELS_DEF,
   parameter int unsigned GAIN_W_P    = GAIN_W_DEF,
   parameter int unsigned RAMP_STEP_P = 1
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [CHANNELS_P*WIDTH_P-1:0]  data_i,
   input  logic                           valid_i,
   output logic                           ready_o,
   output logic [CHANNELS_P*WIDTH_P-1:0]  data_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   input  logic [GAIN_W_P-1:0]            gain_i,
   input  logic                           mute_i,
   output logic                           ramping_o,
   output logic                           clip_o
`ifdef AUDIO_GAIN_PEAK_EN
   ,
   input  logic                           peak_clr_i,
   output logic [CHANNELS_P*WIDTH_P-1:0]  peak_o
`endif
);

   localparam int unsigned FRAME_W = CHANNELS_P * WIDTH_P;
   localparam logic [GAIN_W_P-1:0] STEP = GAIN_W_P'(RAMP_STEP_P);

   logic [GAIN_W_P-1:0] cur_gain_q, cur_gain_d;
   logic [GAIN_W_P-1:0] target;
   logic [GAIN_W_P-1:0] diff;
   ramp_state_e         ramp_state;

   logic                s1_valid_q;
   logic [FRAME_W-1:0]  s1_data_q;
   logic [GAIN_W_P-1:0] s1_gain_q;

   logic                valid_q;
   logic [FRAME_W-1:0]  data_q;
   logic                clip_q;

   logic                adv1, adv2, accept;
   logic [FRAME_W-1:0]  prod_frame;
   logic [CHANNELS_P-1:0] ch_sat;

   assign adv2    = ~valid_q | ready_i;
   assign adv1    = ~s1_valid_q | adv2;
   assign accept  = valid_i & adv1;
   assign ready_o = adv1;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign clip_o  = clip_q;

   // Ramp state is implied by the current gain versus the live target.
   always_comb begin
      target = mute_i ? '0 : gain_i;
      if (cur_gain_q == target) begin
         ramp_state = HOLD;
      end else if (cur_gain_q < target) begin
         ramp_state = UP;
      end else begin
         ramp_state = DOWN;
      end
      ramping_o = (ramp_state != HOLD);
   end

   always_comb begin
      cur_gain_d = cur_gain_q;
      unique case (ramp_state)
         UP:      diff = target - cur_gain_q;
         DOWN:    diff = cur_gain_q - target;
         default: diff = '0;
      endcase
      if (accept) begin
         if (RAMP_STEP_P == 0 || 32'(diff) <= RAMP_STEP_P) begin
            cur_gain_d = target;
         end else if (ramp_state == UP) begin
            cur_gain_d = cur_gain_q + STEP;
         end else begin
            cur_gain_d = cur_gain_q - STEP;
         end
      end
   end

   for (genvar c = 0; c < CHANNELS_P; c++) begin : g_ch
      audio_gain_ch #(
         .WIDTH_P  (WIDTH_P),
         .GAIN_W_P (GAIN_W_P)
      ) u_ch (
         .sample_i (s1_data_q[c*WIDTH_P +: WIDTH_P]),
         .gain_i   (s1_gain_q),
         .result_o (prod_frame[c*WIDTH_P +: WIDTH_P]),
         .sat_o    (ch_sat[c])
      );
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cur_gain_q <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_gain_q  <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         clip_q     <= 1'b0;
      end else begin
         cur_gain_q <= cur_gain_d;
         if (adv1) begin
            s1_valid_q <= valid_i;
         end
         // The frame carries the gain as it stood before this acceptance.
         if (accept) begin
            s1_data_q <= data_i;
            s1_gain_q <= cur_gain_q;
         end
         if (adv2) begin
            valid_q <= s1_valid_q;
         end
         if (adv2 && s1_valid_q) begin
            data_q <= prod_frame;
            clip_q <= |ch_sat;
         end
      end
   end

`ifdef AUDIO_GAIN_PEAK_EN
   localparam logic [WIDTH_P-1:0] MAX_POS = {1'b0, {(WIDTH_P-1){1'b1}}};
   localparam logic [WIDTH_P-1:0] MIN_NEG = {1'b1, {(WIDTH_P-1){1'b0}}};

   logic out_xfer;
   assign out_xfer = valid_q & ready_i;

   for (genvar c = 0; c < CHANNELS_P; c++) begin : g_peak
      logic [WIDTH_P-1:0] sample;
      logic [WIDTH_P-1:0] mag;
      logic [WIDTH_P-1:0] peak_q, peak_d;

      assign sample = data_q[c*WIDTH_P +: WIDTH_P];

      always_comb begin
         if (!sample[WIDTH_P-1]) begin
            mag = sample;
         end else if (sample == MIN_NEG) begin
            mag = MAX_POS;
         end else begin
            mag = (~sample) + WIDTH_P'(1);
         end
         peak_d = peak_q;
         if (peak_clr_i) begin
            peak_d = out_xfer ? mag : '0;
         end else if (out_xfer && mag > peak_q) begin
            peak_d = mag;
         end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            peak_q <= '0;
         end else begin
            peak_q <= peak_d;
         end
      end

      assign peak_o[c*WIDTH_P +: WIDTH_P] = peak_q;
   end
`else
   // Peak metering is compiled out.
`endif

endmodule
